// File: rtl/tail_light_seq_pkg.sv
// Shared state encoding for the tail-light sequencer.
package tail_light_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LRUN = 2'd1,
      ST_RRUN = 2'd2,
      ST_HAZ  = 2'd3
   } state_t;

   // Counter width for a modulus of n, never below one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tail_light_seq_tick_div.sv
// Free-running divider: counts 0..DIV-1 and flags the terminal cycle as a tick.
module tick_div
   import tail_light_seq_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int            W    = cnt_width(DIV);
   localparam logic [W-1:0]  LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // With DIV=1 the counter is stuck at 0 and every cycle ticks.
   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tail_light_seq.sv
// Tail-light sequencer: left/right thermometer fill runs and a hazard blink,
// all advancing only on divider ticks, with registered lamp outputs.
module tail_light_seq
   import tail_light_seq_pkg::*;
#(
   parameter int LAMPS    = 3,
   parameter int TICK_DIV = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             LEFT,
   input  logic             RIGHT,
   input  logic             HAZARD,
   output logic [LAMPS-1:0] L,
   output logic [LAMPS-1:0] R,
   output logic             BUSY
);

   localparam int             SW        = $clog2(LAMPS + 1);
   localparam logic [SW-1:0]  STEP_ONE  = SW'(1);
   localparam logic [SW-1:0]  STEP_LAST = SW'(LAMPS);

   logic             tick;
   state_t           state_q, state_d;
   logic [SW-1:0]    step_q,  step_d;
   logic [LAMPS-1:0] l_q,     l_d;
   logic [LAMPS-1:0] r_q,     r_d;
   logic             busy_q,  busy_d;

   tick_div #(.DIV(TICK_DIV)) u_tick_div (
      .clk   (CLK),
      .rst_n (RST_N),
      .tick  (tick)
   );

   // Lamps lit from the inside out: the low n bits are set.
   function automatic logic [LAMPS-1:0] fill(input logic [SW-1:0] n);
      logic [LAMPS-1:0] v;
      v = '0;
      for (int i = 0; i < LAMPS; i++) begin
         v[i] = (i < int'(n));
      end
      return v;
   endfunction

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      l_d     = l_q;
      r_d     = r_q;
      if (tick) begin
         case (state_q)
            ST_IDLE: begin
               if (HAZARD || (LEFT && RIGHT)) begin
                  state_d = ST_HAZ;
                  l_d     = '1;
                  r_d     = '1;
               end else if (LEFT) begin
                  state_d = ST_LRUN;
                  step_d  = STEP_ONE;
                  l_d     = fill(STEP_ONE);
                  r_d     = '0;
               end else if (RIGHT) begin
                  state_d = ST_RRUN;
                  step_d  = STEP_ONE;
                  l_d     = '0;
                  r_d     = fill(STEP_ONE);
               end
            end
            ST_LRUN, ST_RRUN: begin
               // Hazard wins even on the final step of a run.
               if (HAZARD) begin
                  state_d = ST_HAZ;
                  step_d  = '0;
                  l_d     = '1;
                  r_d     = '1;
               end else if (step_q == STEP_LAST) begin
                  state_d = ST_IDLE;
                  step_d  = '0;
                  l_d     = '0;
                  r_d     = '0;
               end else begin
                  step_d = step_q + 1'b1;
                  if (state_q == ST_LRUN) begin
                     l_d = fill(step_d);
                  end else begin
                     r_d = fill(step_d);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               step_d  = '0;
               l_d     = '0;
               r_d     = '0;
            end
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         l_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         l_q     <= l_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
      end
   end

   assign L    = l_q;
   assign R    = r_q;
   assign BUSY = busy_q;

endmodule
